// File: rtl/aw_sram_loader_if.sv
// Host stream, SRAM write ports and corelet handshake of the weight/activation loader.
// master = loader side, slave = host/corelet/SRAM side.
interface aw_sram_loader_if #(
  parameter int DW = 32,
  parameter int AW = 7
);
  logic          cmd_start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [DW-1:0] W_d;
  logic [AW-1:0] W_addr;
  logic          W_cen;
  logic          W_wen;
  logic [DW-1:0] ACT_d;
  logic [AW-1:0] ACT_addr;
  logic          ACT_cen;
  logic          ACT_wen;
  logic          loader_own;
  logic          seq_begin;
  logic          seq_done;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   checksum;

  modport master (
    input  cmd_start, in_valid, in_data, in_last, seq_done,
    output in_ready, W_d, W_addr, W_cen, W_wen, ACT_d, ACT_addr, ACT_cen, ACT_wen,
    output loader_own, seq_begin, busy, done, err, checksum
  );

  modport slave (
    output cmd_start, in_valid, in_data, in_last, seq_done,
    input  in_ready, W_d, W_addr, W_cen, W_wen, ACT_d, ACT_addr, ACT_cen, ACT_wen,
    input  loader_own, seq_begin, busy, done, err, checksum
  );
endinterface

// File: rtl/aw_sram_loader.sv
// Streams W_WORDS weights then ACT_WORDS activations into the SRAMs (writes one cycle after each
// handshake), kicks the corelet and waits for seq_done. AW_LOADER_CHECKSUM_EN builds the checksum.
module aw_sram_loader #(
  parameter int W_WORDS   = 72,
  parameter int ACT_WORDS = 36,
  parameter int DW        = 32,
  parameter int AW        = 7
) (
  input  logic              clk,
  input  logic              reset,
  aw_sram_loader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_ACT,
    S_KICK,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [AW-1:0] W_LAST   = AW'(W_WORDS - 1);
  localparam logic [AW-1:0] ACT_LAST = AW'(ACT_WORDS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic          w_in_ready;
  logic          w_hs;
  logic          w_start;
  logic          w_wr_w;
  logic          w_wr_act;
  logic          w_cnt_clr;
  logic          w_cnt_inc;

  logic [DW-1:0] r_w_d;
  logic [AW-1:0] r_w_addr;
  logic          r_w_cen;
  logic          r_w_wen;
  logic [DW-1:0] r_act_d;
  logic [AW-1:0] r_act_addr;
  logic          r_act_cen;
  logic          r_act_wen;
  logic          r_seq_begin;

  assign w_in_ready = (r_state == S_LOAD_W) || (r_state == S_LOAD_ACT);
  assign w_hs       = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_wr_w      = 1'b0;
    w_wr_act    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.cmd_start) begin
          w_state_nxt = S_LOAD_W;
          w_start     = 1'b1;
        end else if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end
      end
      // A word whose in_last disagrees with its position is a framing error and is dropped.
      S_LOAD_W: begin
        if (w_hs) begin
          if (bus.in_last != (r_cnt == W_LAST)) begin
            w_state_nxt = S_ERR;
          end else begin
            w_wr_w = 1'b1;
            if (bus.in_last) begin
              w_state_nxt = S_LOAD_ACT;
              w_cnt_clr   = 1'b1;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end
        end
      end
      S_LOAD_ACT: begin
        if (w_hs) begin
          if (bus.in_last != (r_cnt == ACT_LAST)) begin
            w_state_nxt = S_ERR;
          end else begin
            w_wr_act = 1'b1;
            if (bus.in_last) begin
              w_state_nxt = S_KICK;
              w_cnt_clr   = 1'b1;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end
        end
      end
      S_KICK: w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.seq_done) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_start || w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + AW'(1);
    end
  end

  // Address and data hold their last value when no write is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_w_d       <= '0;
      r_w_addr    <= '0;
      r_w_cen     <= 1'b1;
      r_w_wen     <= 1'b1;
      r_act_d     <= '0;
      r_act_addr  <= '0;
      r_act_cen   <= 1'b1;
      r_act_wen   <= 1'b1;
      r_seq_begin <= 1'b0;
    end else begin
      r_w_cen     <= ~w_wr_w;
      r_w_wen     <= ~w_wr_w;
      r_act_cen   <= ~w_wr_act;
      r_act_wen   <= ~w_wr_act;
      r_seq_begin <= (r_state == S_KICK);
      if (w_wr_w) begin
        r_w_addr <= r_cnt;
        r_w_d    <= bus.in_data;
      end
      if (w_wr_act) begin
        r_act_addr <= r_cnt;
        r_act_d    <= bus.in_data;
      end
    end
  end

`ifdef AW_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if (w_start) begin
      r_checksum <= '0;
    end else if (w_wr_w || w_wr_act) begin
      r_checksum <= r_checksum + 32'(bus.in_data);
    end
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = '0;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.W_d        = r_w_d;
  assign bus.W_addr     = r_w_addr;
  assign bus.W_cen      = r_w_cen;
  assign bus.W_wen      = r_w_wen;
  assign bus.ACT_d      = r_act_d;
  assign bus.ACT_addr   = r_act_addr;
  assign bus.ACT_cen    = r_act_cen;
  assign bus.ACT_wen    = r_act_wen;
  assign bus.seq_begin  = r_seq_begin;
  assign bus.loader_own = (r_state != S_RUN);
  assign bus.busy       = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign bus.done       = (r_state == S_DONE);
  assign bus.err        = (r_state == S_ERR);

endmodule
